// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential fetch requests over a req/ack
// handshake and feeds returned words into the instruction buffer slots.
module instr_fetch_sequencer #(
  parameter int unsigned           INSTR_WORD_SIZE = 32,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           BS              = 16,
  parameter int unsigned           PC_STEP         = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc_i,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [INSTR_WORD_SIZE-1:0] mem_rdata_i,
  output logic [INSTR_WORD_SIZE-1:0] instr_in_o,
  output logic [$clog2(BS)-1:0]      buffer_index_o,
  output logic                       wr_valid_o,
  output logic                       buf_primed_o,
  output logic                       flush_o
);

  localparam int unsigned IDX_W  = $clog2(BS);
  localparam int unsigned FILL_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                     state_q,   state_d;
  logic [ADDR_WIDTH-1:0]      pc_q,      pc_d;
  logic                       mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [INSTR_WORD_SIZE-1:0] instr_q,   instr_d;
  logic [IDX_W-1:0]           idx_q,     idx_d;
  logic [IDX_W-1:0]           wr_ptr_q,  wr_ptr_d;
  logic [FILL_W-1:0]          fill_q,    fill_d;
  logic                       wr_valid_q, wr_valid_d;
  logic                       primed_q,  primed_d;
  logic                       flush_q,   flush_d;

  logic [ADDR_WIDTH-1:0]      pc_inc;
  logic                       fill_full;

  assign pc_inc    = pc_q + ADDR_WIDTH'(PC_STEP);
  assign fill_full = (fill_q == FILL_W'(BS));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    wr_valid_d = 1'b0;
    flush_d    = 1'b0;
    primed_d   = fill_full;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end

      REQ, HOLD: begin
        if (redirect_valid_i) begin
          // Redirect beats a same-cycle ack; the returned word is dropped
          state_d    = stall_i ? HOLD : REQ;
          pc_d       = redirect_pc_i;
          mem_req_d  = 1'b0;
          mem_addr_d = redirect_pc_i;
          fill_d     = '0;
          primed_d   = 1'b0;
          flush_d    = 1'b1;
        end else if (state_q == HOLD) begin
          if (!stall_i) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end else if (!mem_req_q) begin
          // Bubble after a redirect: raise the request unless stalled
          if (stall_i) begin
            state_d = HOLD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end else if (mem_ack_i) begin
          instr_d    = mem_rdata_i;
          idx_d      = wr_ptr_q;
          wr_ptr_d   = wr_ptr_q + IDX_W'(1);
          pc_d       = pc_inc;
          wr_valid_d = 1'b1;
          fill_d     = fill_full ? fill_q : fill_q + FILL_W'(1);
          mem_addr_d = pc_inc;
          if (stall_i) begin
            state_d   = HOLD;
            mem_req_d = 1'b0;
          end else begin
            state_d   = REQ;
            mem_req_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      instr_q    <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      wr_valid_q <= 1'b0;
      primed_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      wr_valid_q <= wr_valid_d;
      primed_q   <= primed_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;
  assign instr_in_o     = instr_q;
  assign buffer_index_o = idx_q;
  assign wr_valid_o     = wr_valid_q;
  assign buf_primed_o   = primed_q;
  assign flush_o        = flush_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Scoreboard bench for instr_fetch_sequencer: a transaction-level model predicts
// every capture, request and flag; a monitor compares after each rising edge.
module tb_instr_fetch_sequencer;

  localparam int unsigned BS  = 4;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk;
  logic        rst_ni;
  logic        start_i, stall_i, redirect_valid_i, mem_ack_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_in_o;
  logic [1:0]  buffer_index_o;
  logic        wr_valid_o, buf_primed_o, flush_o;

  instr_fetch_sequencer #(
    .INSTR_WORD_SIZE(32),
    .ADDR_WIDTH     (32),
    .BS             (BS),
    .PC_STEP        (4),
    .RESET_PC       (RPC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_in_o      (instr_in_o),
    .buffer_index_o  (buffer_index_o),
    .wr_valid_o      (wr_valid_o),
    .buf_primed_o    (buf_primed_o),
    .flush_o         (flush_o)
  );

  // Memory returns a word derived from the requested address
  assign mem_rdata_i = mem_addr_o ^ 32'h0000_A5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en;

  // Reference model: what the outputs must be after the next rising edge
  logic        m_started, m_req, m_hold;
  logic [31:0] m_pc;
  logic [1:0]  m_wp;
  int          m_caps;
  logic        exp_primed, exp_flush, exp_wv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started  = 1'b0;
    m_req      = 1'b0;
    m_hold     = 1'b0;
    m_pc       = RPC;
    m_wp       = 2'd0;
    m_caps     = 0;
    exp_primed = 1'b0;
    exp_flush  = 1'b0;
    exp_wv     = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus at the falling edge and predict its effect
  task automatic step(input logic st, input logic sl, input logic rv,
                      input logic [31:0] rpc, input logic ak);
    @(negedge clk);
    start_i          = st;
    stall_i          = sl;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    mem_ack_i        = ak & mem_req_o;
    exp_flush        = 1'b0;
    exp_wv           = 1'b0;
    if (!m_started) begin
      exp_primed = 1'b0;
      if (st) begin
        m_started = 1'b1;
        m_req     = 1'b1;
      end
    end else begin
      exp_primed = !rv && (m_caps >= int'(BS));
      if (rv) begin
        m_pc      = rpc;
        m_caps    = 0;
        m_req     = 1'b0;
        m_hold    = sl;
        exp_flush = 1'b1;
      end else if (m_hold) begin
        if (!sl) begin
          m_hold = 1'b0;
          m_req  = 1'b1;
        end
      end else if (!m_req) begin
        if (sl) m_hold = 1'b1;
        else    m_req  = 1'b1;
      end else if (mem_ack_i) begin
        exp_q.push_back('{data: m_pc ^ 32'h0000_A5A5, idx: m_wp});
        exp_wv = 1'b1;
        m_pc   = m_pc + 32'd4;
        m_wp   = m_wp + 2'd1;
        m_caps++;
        if (sl) begin
          m_req  = 1'b0;
          m_hold = 1'b1;
        end
      end
    end
  endtask

  // Monitor: compare DUT against the model shortly after every rising edge
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("mem_req", 32'(mem_req_o), 32'(m_req));
      if (m_req) chk("mem_addr", mem_addr_o, m_pc);
      chk("flush", 32'(flush_o), 32'(exp_flush));
      chk("buf_primed", 32'(buf_primed_o), 32'(exp_primed));
      chk("wr_valid", 32'(wr_valid_o), 32'(exp_wv));
      if (wr_valid_o) begin
        chk("capture_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr_in", instr_in_o, e.data);
          chk("buffer_index", 32'(buffer_index_o), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    mon_en           = 1'b0;
    rst_ni           = 1'b0;
    start_i          = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;
    mem_ack_i        = 1'b0;
    model_reset();

    #7;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, RPC);
    chk("rst_instr_in", instr_in_o, 32'd0);
    chk("rst_buffer_index", 32'(buffer_index_o), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("rst_buf_primed", 32'(buf_primed_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Idle, then start with back-to-back acks through buffer wrap
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h999, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    // Delayed ack: request must sit stable for three cycles
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    // Stall raised while waiting; capture still completes, then hold
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    // Redirect colliding with an ack
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    // Redirect while stalled, start outside idle
    step(1'b0, 1'b1, 1'b1, 32'h800, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized traffic, including pc wrap-around targets
    for (int i = 0; i < 2000; i++) begin
      logic        st, sl, rv, ak;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 49) == 0);
      sl  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      ak  = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      step(st, sl, rv, rpc, ak);
    end

    // Fill the buffer, then hit reset between clock edges
    repeat (8) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("async_rst_wr_valid", 32'(wr_valid_o), 32'd0);
    chk("async_rst_buf_primed", 32'(buf_primed_o), 32'd0);
    chk("async_rst_buffer_index", 32'(buffer_index_o), 32'd0);
    start_i          = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    mem_ack_i        = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    chk("pending_captures", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
